fios_res_collector: RTL
=======================

# fios_res_collector

Result collector and final-reduction stage at the output of the Montgomery FIOS multiplier. Receives the multiplier's serial 17-bit result stream (least significant word first) and reassembles it into a full s·17-bit operand. While the words arrive it performs the Montgomery conditional subtraction (R ≥ p → R − p) word-serially with a borrow chain. It presents the reduced result on a valid/ready output port.

## Interface

Parameters:
- s, 8, number of 17-bit words per operand; must match the multiplier's s; s ≥ 1.
- SUBTRACT, 1, 1 = perform the conditional subtraction; 0 = pass R through unchanged.

Ports:
- clock_i  input  1  single clock; all logic on its rising edge.
- reset_n_i  input  1  reset, synchronous, active-low.
- res_valid_i  input  1  the word on res_i is valid this cycle; may have gaps.
- res_i  input  17  result word from the multiplier's RES_o.
- p_i  input  s*17  modulus; word k is at bits [17k+16:17k]; held stable from the first word until result_valid_o rises.
- result_o  output  s*17  reduced result, same word packing as p_i.
- result_valid_o  output  1  result_o holds an unconsumed result.
- result_ready_i  input  1  consumer accepts result_o.
- busy_o  output  1  collection in progress (collector state COLLECT).
- overflow_o  output  1  sticky flag: a completed result was discarded.

## Operation

- Collector FSM states:
  - IDLE: word counter k = 0, borrow = 0.
  - IDLE → COLLECT: on the first res_valid_i. If s == 1, completion occurs on that word instead.
  - COLLECT: each res_valid_i stores res_i into raw buffer word k and stores diff_k into diff buffer word k.
    - diff_k = res_i − p_k − borrow, computed at 18 bits. Bit 17 is the new borrow; bits 16:0 are stored.
    - k increments.
  - COLLECT → IDLE: on the word with k = s−1. That edge raises a one-cycle internal done pulse, and k and borrow clear.
  - Cycles without res_valid_i hold all state.
- Selection is driven by the final borrow:
  - final borrow = 0 (R ≥ p) and SUBTRACT = 1 → load the diff buffer.
  - Otherwise → load the raw buffer.
  - R = p yields an all-zero result.
- Output stage: on the edge following done, load result_o and set result_valid_o. This happens only if the stage is empty, or is being drained that same cycle (result_valid_o & result_ready_i).
  - Otherwise the new result is discarded, overflow_o sets, and result_o/result_valid_o are untouched.
- Handshake: a transfer occurs on any edge where result_valid_o & result_ready_i. result_valid_o then clears unless a new load occurs on the same edge, in which case it stays high with the new data.
- Collection of the next result proceeds concurrently while result_valid_o is high (back-to-back multiplications are not stalled).
- overflow_o clears only on reset.
- Reset (synchronous, reset_n_i = 0 at an edge): result_o = 0, result_valid_o = 0, busy_o = 0, overflow_o = 0, FIOS state = IDLE, k = 0, borrow = 0.
  - A partial collection in progress is discarded.
  - res_valid_i is ignored during reset.
- res_valid_i together with a pending done on the same edge is legal: the new word starts the next collection as word 0.

## Timing

- Latency: last word sampled at edge E → result_valid_o high and result_o valid after edge E+1.
- busy_o rises after the edge sampling the first word and falls after edge E.
- Minimum spacing between completed results is s cycles (one word per cycle). No bubbles are required between results.
- result_o is stable while result_valid_o is high and result_ready_i is low.
- No combinational path from any input to any output. All outputs are registered.

## Test plan

All scenarios use s = 2, SUBTRACT = 1, p = {w1 = 17'h00001, w0 = 17'h00005}.

- Reset and idle: hold reset_n_i = 0 for 3 cycles, then release with no input → all outputs 0 indefinitely.
- R ≥ p: words 17'h00007 then 17'h00001 on consecutive cycles, result_ready_i = 1 → result_valid_o pulses for one cycle 2 cycles after the last word, with result_o = {17'h00000, 17'h00002}.
- R < p, with gaps: word 17'h00003, 2 idle cycles, then word 17'h00001 → result_o = {17'h00001, 17'h00003}. busy_o is high throughout the gap.
- Borrow propagation and equality:
  - Words 17'h00002, 17'h00002 → result_o = {17'h00000, 17'h1FFFD}.
  - Words 17'h00005, 17'h00001 → result_o = 0.
- Back-pressure and overflow: result_ready_i = 0; two results are sent back-to-back.
  - The first result is held unchanged.
  - overflow_o sets 2 cycles after the second result's last word.
  - After result_ready_i rises, one transfer occurs and result_valid_o drops.
- Reset mid-collection: send word 0, assert reset for one cycle, then send a full result 17'h00007, 17'h00001 → result_o = {0, 2}. The pre-reset word has no effect.

Source files
------------

// File: rtl/fios_res_collector.sv
// Collects the FIOS multiplier's serial result words, performs the word-serial
// conditional subtraction R - p, and presents the reduced operand on a valid/ready port.
module fios_res_collector #(
  parameter int s        = 8,
  parameter int SUBTRACT = 1
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            res_valid_i,
  input  logic [16:0]     res_i,
  input  logic [s*17-1:0] p_i,
  output logic [s*17-1:0] result_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic            busy_o,
  output logic            overflow_o
);

  localparam int K_W = (s > 1) ? $clog2(s) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            borrow_q, borrow_d;
  logic            done_q, done_d;
  logic            fin_borrow_q, fin_borrow_d;
  logic [16:0]     raw_q [s];
  logic [16:0]     raw_d [s];
  logic [16:0]     diff_q [s];
  logic [16:0]     diff_d [s];
  logic [s*17-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            overflow_q, overflow_d;

  logic [16:0]     p_words [s];
  logic [17:0]     diff_full;
  logic            last_word;
  logic            drain;
  logic            load;
  logic            use_diff;

  // Collection stage: one word per res_valid_i, borrow rippling across words
  always_comb begin
    for (int i = 0; i < s; i++) begin
      p_words[i] = p_i[17*i +: 17];
    end
    diff_full = {1'b0, res_i} - {1'b0, p_words[k_q]} - {17'b0, borrow_q};
    last_word = (k_q == K_W'(s - 1));

    state_d      = state_q;
    k_d          = k_q;
    borrow_d     = borrow_q;
    done_d       = 1'b0;
    fin_borrow_d = fin_borrow_q;
    raw_d        = raw_q;
    diff_d       = diff_q;

    if (res_valid_i) begin
      raw_d[k_q]  = res_i;
      diff_d[k_q] = diff_full[16:0];
      if (last_word) begin
        state_d      = IDLE;
        k_d          = '0;
        borrow_d     = 1'b0;
        done_d       = 1'b1;
        fin_borrow_d = diff_full[17];
      end else begin
        state_d  = COLLECT;
        k_d      = k_q + 1'b1;
        borrow_d = diff_full[17];
      end
    end
  end

  // Output stage: load on the edge after done, unless an undrained result blocks it
  always_comb begin
    drain    = valid_q & result_ready_i;
    load     = done_q & (~valid_q | drain);
    use_diff = (SUBTRACT != 0) && !fin_borrow_q;

    result_d = result_q;
    if (load) begin
      for (int i = 0; i < s; i++) begin
        result_d[17*i +: 17] = use_diff ? diff_q[i] : raw_q[i];
      end
    end

    if (load)       valid_d = 1'b1;
    else if (drain) valid_d = 1'b0;
    else            valid_d = valid_q;

    overflow_d = overflow_q | (done_q & ~load);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      borrow_q   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      borrow_q   <= borrow_d;
      done_q     <= done_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Word buffers are qualified by done_q, so they need no reset
  always_ff @(posedge clock_i) begin
    fin_borrow_q <= fin_borrow_d;
    raw_q        <= raw_d;
    diff_q       <= diff_d;
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q == COLLECT);
  assign overflow_o     = overflow_q;

endmodule
